hazard_forward_unit: RTL

- Parametrised decode-stage data-dependency unit for the pipelined core.
- Latches one instruction per cycle into a decode register and tracks destination registers of DEPTH older in-flight instructions.
- Produces per-operand forwarding selects for the execute operand muxes.
- Generalises the fixed 3-stage scheme: parametric register/opcode widths and depth, write-enable qualification, r0 exclusion, valid/ready handshake with a one-bubble load-use stall, flush, and a saturating stall counter.

---
 rtl/hazard_forward_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/hazard_forward_unit.sv
// Decode-stage dependency unit: latches one instruction per cycle, tracks older destinations,
// and produces execute-stage forwarding selects plus a one-bubble load-use stall.
module hazard_forward_unit #(
  parameter int unsigned OP_W  = 5,
  parameter int unsigned REG_W = 5,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned SEL_W = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [REG_W-1:0] in_rd,
  input  logic [REG_W-1:0] in_rs_a,
  input  logic [REG_W-1:0] in_rs_b,
  input  logic             in_use_a,
  input  logic             in_use_b,
  input  logic             in_wr_en,
  input  logic             in_is_load,
  input  logic             flush,
  output logic             dec_valid,
  output logic [OP_W-1:0]  dec_op,
  output logic [REG_W-1:0] dec_rd,
  output logic [SEL_W-1:0] sel_a,
  output logic [SEL_W-1:0] sel_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs_a;
    logic [REG_W-1:0] rs_b;
    logic             use_a;
    logic             use_b;
    logic             wr_en;
    logic             is_load;
  } dec_t;

  // Load flag is not kept per history entry: only the decode slot can raise a stall.
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
  } hist_t;

  dec_t             dec_q, dec_d;
  hist_t            hist_q [DEPTH];
  hist_t            hist_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             haz;

  // Load-use hazard between the incoming instruction and a load sitting in decode.
  always_comb begin
    haz = 1'b0;
    if (in_valid && dec_q.valid && dec_q.is_load && dec_q.wr_en && (dec_q.rd != '0)) begin
      haz = (in_use_a && (in_rs_a == dec_q.rd)) || (in_use_b && (in_rs_b == dec_q.rd));
    end
  end

  assign stall    = reset & haz & ~flush;
  assign in_ready = reset & ~haz & ~flush;

  // Forwarding selects: scan oldest to youngest so the nearest match overwrites.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (hist_q[k].v && (hist_q[k].rd == dec_q.rs_a)) sel_a = SEL_W'(k + 1);
      if (hist_q[k].v && (hist_q[k].rd == dec_q.rs_b)) sel_b = SEL_W'(k + 1);
    end
    if (!reset || !dec_q.valid || !dec_q.use_a || (dec_q.rs_a == '0)) sel_a = '0;
    if (!reset || !dec_q.valid || !dec_q.use_b || (dec_q.rs_b == '0)) sel_b = '0;
  end

  // Next-state: decode register, history shift, saturating stall counter.
  always_comb begin
    dec_d = '0;
    if (!flush && in_valid && in_ready) begin
      dec_d.valid   = 1'b1;
      dec_d.op      = in_op;
      dec_d.rd      = in_rd;
      dec_d.rs_a    = in_rs_a;
      dec_d.rs_b    = in_rs_b;
      dec_d.use_a   = in_use_a;
      dec_d.use_b   = in_use_b;
      dec_d.wr_en   = in_wr_en;
      dec_d.is_load = in_is_load;
    end

    hist_d[0].v  = dec_q.valid & dec_q.wr_en & (dec_q.rd != '0);
    hist_d[0].rd = dec_q.rd;
    for (int k = 1; k < int'(DEPTH); k++) begin
      hist_d[k] = hist_q[k-1];
    end

    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dec_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        hist_q[k] <= '0;
      end
    end else begin
      dec_q <= dec_d;
      cnt_q <= cnt_d;
      for (int k = 0; k < int'(DEPTH); k++) begin
        hist_q[k] <= hist_d[k];
      end
    end
  end

  assign dec_valid = dec_q.valid;
  assign dec_op    = dec_q.op;
  assign dec_rd    = dec_q.rd;
  assign stall_cnt = cnt_q;

endmodule
